// File: rtl/common_pseudo_lru_set_alloc.sv
// common_pseudo_lru_set_alloc
//   Multi-set tree pseudo-LRU victim allocator. One (WAYS-1)-bit PLRU tree per
//   set. An accepted allocate returns a one-hot victim one cycle later and
//   touches that victim in its set's tree. Hit-touches update a tree directly.
//   A flush clears every tree sequentially, one set per cycle.
//
// Ports
//   clk, reset        clock / asynchronous active-low reset
//   touch_en/set/way  hit-touch strobe, set index, one-hot way
//   alloc_valid/ready allocate handshake
//   alloc_set/mask    set index and eligible-way mask for the allocate
//   resp_valid        one-cycle pulse with the victim result
//   resp_way          one-hot victim (all-zero when no way was eligible)
//   resp_none         the allocate mask was empty
//   flush_req/busy    start a flush of all trees / flush in progress
module common_pseudo_lru_set_alloc #(
    parameter int WAY_LOG2 = 2,
    parameter int SET_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       touch_en,
    input  logic [SET_LOG2-1:0]        touch_set,
    input  logic [(1<<WAY_LOG2)-1:0]   touch_way,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [SET_LOG2-1:0]        alloc_set,
    input  logic [(1<<WAY_LOG2)-1:0]   alloc_mask,
    output logic                       resp_valid,
    output logic [(1<<WAY_LOG2)-1:0]   resp_way,
    output logic                       resp_none,
    input  logic                       flush_req,
    output logic                       flush_busy
);
    localparam int WAYS     = 1 << WAY_LOG2;
    localparam int NUM_SETS = 1 << SET_LOG2;
    localparam int NODES    = WAYS - 1;

    typedef logic [NODES-1:0] tree_t;
    typedef enum logic {IDLE, FLUSH} state_t;

    // Walk from the root. At each node look at which half of the node's way
    // range still holds an eligible way; only when both halves do does the
    // node bit decide (1 = right).
    function automatic logic [WAY_LOG2-1:0] pick_way(input tree_t t, input logic [WAYS-1:0] m);
        int              n, base, half;
        logic [WAYS-1:0] lmask, rmask;
        tree_t           ts;
        logic            any_l, any_r, go_r;
        n    = 0;
        base = 0;
        for (int l = 0; l < WAY_LOG2; l++) begin
            half  = WAYS >> (l + 1);
            lmask = ((WAYS'(1) << half) - WAYS'(1)) << base;
            rmask = lmask << half;
            any_l = |(m & lmask);
            any_r = |(m & rmask);
            ts    = t >> n;
            go_r  = any_r & (~any_l | ts[0]);
            if (go_r) base = base + half;
            n = 2 * n + (go_r ? 2 : 1);
        end
        return WAY_LOG2'(base);
    endfunction

    // Path update for touching way w: {write-enable, value}. A node on the
    // path is written 1 when w sits in its left subtree, pointing the next
    // victim away from w.
    function automatic logic [2*NODES-1:0] path_upd(input logic [WAY_LOG2-1:0] w);
        tree_t               en, val;
        logic [WAY_LOG2-1:0] ws;
        int                  n;
        en  = '0;
        val = '0;
        n   = 0;
        for (int l = 0; l < WAY_LOG2; l++) begin
            ws = w >> (WAY_LOG2 - 1 - l);
            en = en | (tree_t'(1) << n);
            if (!ws[0]) val = val | (tree_t'(1) << n);
            n = 2 * n + (ws[0] ? 2 : 1);
        end
        return {en, val};
    endfunction

    function automatic tree_t apply_upd(input tree_t t, input logic [2*NODES-1:0] u);
        return (t & ~u[2*NODES-1:NODES]) | u[NODES-1:0];
    endfunction

    state_t                          state;
    logic [SET_LOG2-1:0]             flush_cnt;
    logic [NUM_SETS-1:0][NODES-1:0]  trees, tree_nxt;
    logic [WAY_LOG2-1:0]             victim_idx, touch_idx;
    logic                            accept, alloc_none, touch_ok;

    assign accept     = alloc_valid & alloc_ready;
    assign alloc_none = ~|alloc_mask;
    assign touch_ok   = touch_en & (state == IDLE);
    assign victim_idx = pick_way(trees[alloc_set], alloc_mask);

    always_comb begin
        touch_idx = '0;
        for (int i = 0; i < WAYS; i++)
            if (touch_way[i]) touch_idx = touch_idx | WAY_LOG2'(i);
    end

    // Touch is applied after the allocate so that, on a shared set, the
    // touch path wins on every node both paths write.
    always_comb begin
        tree_nxt = trees;
        if (state == FLUSH) begin
            tree_nxt[flush_cnt] = '0;
        end else begin
            if (accept && !alloc_none)
                tree_nxt[alloc_set] = apply_upd(tree_nxt[alloc_set], path_upd(victim_idx));
            if (touch_ok)
                tree_nxt[touch_set] = apply_upd(tree_nxt[touch_set], path_upd(touch_idx));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) trees <= '0;
        else        trees <= tree_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            alloc_ready <= 1'b1;
            flush_busy  <= 1'b0;
            resp_valid  <= 1'b0;
            resp_way    <= '0;
            resp_none   <= 1'b0;
        end else begin
            resp_valid <= accept;
            if (accept) begin
                resp_way  <= alloc_none ? '0 : (WAYS'(1) << victim_idx);
                resp_none <= alloc_none;
            end
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state       <= FLUSH;
                        flush_cnt   <= '0;
                        alloc_ready <= 1'b0;
                        flush_busy  <= 1'b1;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + SET_LOG2'(1);
                    if (&flush_cnt) begin
                        state       <= IDLE;
                        alloc_ready <= 1'b1;
                        flush_busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    touch_way_onehot: assert property (@(posedge clk) disable iff (!reset)
        touch_en |-> $onehot(touch_way));

endmodule

// File: doc/common_pseudo_lru_set_alloc.md
Name: common_pseudo_lru_set_alloc

Overview:
- Multi-set tree pseudo-LRU victim allocator for set-associative structures such as caches and TLBs.
- Holds one (WAYS-1)-bit PLRU tree per set.
- Accepts a registered allocate request with a per-way candidate mask and returns a one-hot victim one cycle later, updating that set's tree as if the victim were touched.
- Supports independent hit-touch updates and a multi-cycle sequential flush of all trees.

Parameters:
- WAY_LOG2, 2: log2 of way count; must be at least 1. WAYS = 1 << WAY_LOG2.
- SET_LOG2, 4: log2 of set count. NUM_SETS = 1 << SET_LOG2.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- touch_en  in  1  hit-touch strobe.
- touch_set  in  SET_LOG2  set index for the touch.
- touch_way  in  WAYS  one-hot way touched.
- alloc_valid  in  1  allocate request.
- alloc_ready  out  1  allocator can accept a request.
- alloc_set  in  SET_LOG2  set index to allocate in.
- alloc_mask  in  WAYS  eligible candidate ways; 1 = may be picked.
- resp_valid  out  1  one-cycle pulse; victim result valid.
- resp_way  out  WAYS  one-hot victim, or all-zero.
- resp_none  out  1  no eligible way (alloc_mask was zero).
- flush_req  in  1  request clear of all trees.
- flush_busy  out  1  flush in progress.

Behaviour:
- Tree layout: node n has children 2n+1 (a/left) and 2n+2 (b/right). Leaves WAYS-1+i map to way i.
- Node bit 0 steers the next victim left; bit 1 steers it right.
- Touch rule (way w): each node on w's path is written 1 if w lies in its left subtree, else 0. Off-path nodes hold.
- Pick rule (set s, mask m), from the root:
  - If exactly one child subtree contains a set bit of m, descend into it.
  - If both do, follow the node bit.
  - If m == 0, the result is all-zero and resp_none = 1.
- Allocate handshake:
  - Request is accepted on a cycle with alloc_valid & alloc_ready.
  - Victim is computed from pre-edge tree state and registered.
  - At cycle+1: resp_valid=1, resp_way=victim, resp_none=(mask==0).
  - resp_valid is a single-cycle pulse with no backpressure; resp_way/resp_none hold their last value otherwise.
  - On the accept edge, set alloc_set's tree is updated per the touch rule with the victim way, unless resp_none.
  - Back-to-back allocates to the same set see the updated state; throughput is 1 per cycle.
- Touch: when touch_en=1 and state is IDLE, touch_set's tree is updated per the touch rule at the edge.
- Simultaneous touch and allocate:
  - Different sets: both updates apply.
  - Same set: per node bit, touch-path update wins, else alloc-path update, else hold.
  - The victim is still computed from pre-edge state.
- FSM states IDLE and FLUSH:
  - IDLE: alloc_ready=1, flush_busy=0. flush_req=1 moves to FLUSH with set counter=0.
  - A same-cycle allocate or touch is still honoured before the flush starts.
  - FLUSH: alloc_ready=0, flush_busy=1. Each cycle clears the tree of set[counter] to all-zero and increments the counter.
  - After set NUM_SETS-1 is cleared, return to IDLE. Busy lasts exactly NUM_SETS cycles.
  - During FLUSH, touch_en, alloc_valid and flush_req are ignored.
  - Counter width is SET_LOG2 and wraps naturally at completion.
- Reset (asserted low, takes effect immediately without a clock):
  - All tree bits 0, state IDLE, counter 0.
  - resp_valid=0, resp_way=0, resp_none=0, flush_busy=0.
  - alloc_ready=1 once reset is released.
  - Reset during FLUSH aborts the flush; trees are cleared by reset anyway.
- Out-of-contract inputs: non-one-hot touch_way, and alloc_set/touch_set X, are undefined. An assertion flags touch_way not one-hot when touch_en=1.

Test Plan (WAY_LOG2=2, SET_LOG2=2):
- Sequence: after reset, 5 back-to-back allocates on set0 with mask 1111 -> resp_way = 0001, 0100, 0010, 1000, 0001, with resp_valid pulsing each cycle after acceptance.
- Mask steering: after reset, set0 mask 0110 -> 0010; repeat -> 0100. Set0 mask 1000 -> 1000 regardless of tree bits.
- Empty mask: mask 0000 -> resp_valid=1, resp_none=1, resp_way=0000; a following mask-1111 allocate still returns 0001, proving no state change.
- Set isolation and collision:
  - touch set1 way 0001, then alloc set1 mask 1111 -> 0100; alloc set2 -> 0001.
  - After reset, same-cycle alloc set0 mask 1111 with touch set0 way 1000 -> resp 0001; next alloc set0 -> 0010.
- Flush: after mixed traffic, pulse flush_req -> flush_busy=1 and alloc_ready=0 for exactly 4 cycles, and touches/allocs in that window are ignored; afterwards an alloc on each of sets 0..3 -> 0001.
- Async reset: assert reset mid-flush and mid-response -> flush_busy, resp_valid, resp_way drop to 0 without a clock edge; after release, alloc set0 -> 0001.
